// File: rtl/tensor_product_scheduler.sv
// Round-robin scheduler sharing one tensor_product datapath among NUM_REQ requesters.
// Job completion is timed by a local counter because the datapath valid flag is sticky.
module tensor_product_scheduler #(
  parameter int NUM_REQ           = 2,
  parameter int A_VECTOR_LEN      = 5,
  parameter int B_VECTOR_LEN      = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int TILING_H          = 1,
  parameter int TILING_V          = 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [NUM_REQ-1:0]                                    req,
  input  logic [NUM_REQ*A_VECTOR_LEN*A_CELL_WIDTH-1:0]          req_a,
  input  logic [NUM_REQ*B_VECTOR_LEN*B_CELL_WIDTH-1:0]          req_b,
  output logic [NUM_REQ-1:0]                                    grant,
  output logic [NUM_REQ-1:0]                                    done,
  output logic                                                  done_error,
  output logic [A_VECTOR_LEN*B_VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
  output logic                                                  busy,
  output logic                                                  tp_start,
  output logic [A_VECTOR_LEN*A_CELL_WIDTH-1:0]                  tp_a,
  output logic [B_VECTOR_LEN*B_CELL_WIDTH-1:0]                  tp_b,
  input  logic [A_VECTOR_LEN*B_VECTOR_LEN*RESULT_CELL_WIDTH-1:0] tp_result,
  input  logic                                                  tp_error
);

  localparam int A_BITS     = A_VECTOR_LEN * A_CELL_WIDTH;
  localparam int B_BITS     = B_VECTOR_LEN * B_CELL_WIDTH;
  localparam int RUN_CYCLES = ((A_VECTOR_LEN + TILING_V - 1) / TILING_V) *
                              ((B_VECTOR_LEN + TILING_H - 1) / TILING_H);
  localparam int CNT_W      = $clog2(RUN_CYCLES + 1);
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LAUNCH  = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               err_snap;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   winner;
  logic               found;
  logic [NUM_REQ-1:0] winner_onehot;
  logic [A_BITS-1:0]  sel_a;
  logic [B_BITS-1:0]  sel_b;

  // Round-robin search begins just after the previous owner so nobody starves.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req[(int'(last_grant) + i) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    sel_a         = '0;
    sel_b         = '0;
    winner_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == IDX_W'(k)) begin
        sel_a            = req_a[k*A_BITS +: A_BITS];
        sel_b            = req_b[k*B_BITS +: B_BITS];
        winner_onehot[k] = 1'b1;
      end
    end
  end

  assign busy = (state != S_IDLE);

  // Operands are latched at grant and held until capture; the datapath reads them every run cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      done       <= '0;
      done_error <= 1'b0;
      tp_start   <= 1'b0;
      result     <= '0;
      tp_a       <= '0;
      tp_b       <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      wait_cnt   <= '0;
      err_snap   <= 1'b0;
    end else begin
      tp_start   <= 1'b0;
      done       <= '0;
      done_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant    <= winner_onehot;
            owner    <= winner;
            tp_a     <= sel_a;
            tp_b     <= sel_b;
            tp_start <= 1'b1;
            state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          err_snap <= tp_error;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == CNT_W'(RUN_CYCLES - 1)) begin
            state <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          result     <= tp_result;
          done       <= grant;
          done_error <= tp_error & ~err_snap;
          last_grant <= owner;
          grant      <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_product_scheduler.sv
// Randomized self-checking bench for tensor_product_scheduler with a job-level reference model
// and a behavioural fixed-point (4 fractional bits) datapath stand-in.
module tb_tensor_product_scheduler;

  localparam int NUM_REQ = 2;
  localparam int AL      = 5;
  localparam int BL      = 5;
  localparam int AW      = 8;
  localparam int BW      = 8;
  localparam int RW      = 8;
  localparam int AV      = AL * AW;
  localparam int BV      = BL * BW;
  localparam int RV      = AL * BL * RW;
  localparam int RUN     = 25;

  logic                    clk;
  logic                    rst;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*AV-1:0]   req_a;
  logic [NUM_REQ*BV-1:0]   req_b;
  logic [NUM_REQ-1:0]      grant;
  logic [NUM_REQ-1:0]      done;
  logic                    done_error;
  logic [RV-1:0]           result;
  logic                    busy;
  logic                    tp_start;
  logic [AV-1:0]           tp_a;
  logic [BV-1:0]           tp_b;
  logic [RV-1:0]           tp_result;
  logic                    tp_error;

  logic [NUM_REQ-1:0]      req2;
  logic [NUM_REQ-1:0]      grant2;
  logic [NUM_REQ-1:0]      done2;
  logic                    done_error2;
  logic [RV-1:0]           result2;
  logic                    busy2;
  logic                    tp_start2;
  logic [AV-1:0]           tp_a2;
  logic [BV-1:0]           tp_b2;
  logic [RV-1:0]           tp_result2;
  logic                    tp_error2;

  int checks;
  int errors;

  tensor_product_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .grant(grant), .done(done), .done_error(done_error), .result(result),
    .busy(busy), .tp_start(tp_start), .tp_a(tp_a), .tp_b(tp_b),
    .tp_result(tp_result), .tp_error(tp_error)
  );

  tensor_product_scheduler #(.TILING_H(2), .TILING_V(2)) dut_tiled (
    .clk(clk), .rst(rst), .req(req2), .req_a(req_a), .req_b(req_b),
    .grant(grant2), .done(done2), .done_error(done_error2), .result(result2),
    .busy(busy2), .tp_start(tp_start2), .tp_a(tp_a2), .tp_b(tp_b2),
    .tp_result(tp_result2), .tp_error(tp_error2)
  );

  assign tp_result2 = {AL{tp_a2 ^ tp_b2}};
  assign tp_error2  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed cell multiply with 4 fractional bits; bit 8 flags saturation.
  function automatic logic [8:0] cell_mul(input logic signed [7:0] x, input logic signed [7:0] y);
    int p;
    p = (int'(x) * int'(y)) >>> 4;
    if (p > 127)  return {1'b1, 8'h7F};
    if (p < -128) return {1'b1, 8'h80};
    return {1'b0, p[7:0]};
  endfunction

  function automatic logic [RV:0] outer(input logic [AV-1:0] a, input logic [BV-1:0] b);
    logic [RV:0] r;
    logic [8:0]  c;
    r = '0;
    for (int i = 0; i < AL; i++) begin
      for (int j = 0; j < BL; j++) begin
        c = cell_mul(a[i*AW +: AW], b[j*BW +: BW]);
        r[(i*BL + j)*RW +: RW] = c[7:0];
        r[RV] = r[RV] | c[8];
      end
    end
    return r;
  endfunction

  function automatic logic [AV-1:0] rand_vec();
    logic [AV-1:0] v;
    for (int i = 0; i < AL; i++) begin
      if ($urandom_range(39) == 0) v[i*AW +: AW] = 8'h7F;
      else                         v[i*AW +: AW] = 8'($urandom_range(63)) - 8'd32;
    end
    return v;
  endfunction

  // Datapath stand-in: result and sticky error appear after RUN cycles following start.
  logic [RV:0] dp_calc;
  int          dp_cnt;
  assign dp_calc = outer(tp_a, tp_b);

  always @(posedge clk) begin
    if (rst) begin
      dp_cnt    <= 0;
      tp_result <= '0;
      tp_error  <= 1'b0;
    end else if (tp_start) begin
      dp_cnt <= RUN;
    end else if (dp_cnt != 0) begin
      dp_cnt <= dp_cnt - 1;
      if (dp_cnt == 1) begin
        tp_result <= dp_calc[RV-1:0];
        if (dp_calc[RV]) tp_error <= 1'b1;
      end
    end
  end

  // Job-level reference: age counts cycles since the arbitration edge, 0 means idle.
  int                 m_age;
  int                 m_last;
  int                 m_owner;
  logic [AV-1:0]      m_a;
  logic [BV-1:0]      m_b;
  logic               m_sticky;
  logic               m_snap_err;
  logic [RV-1:0]      m_result;
  logic [NUM_REQ-1:0] m_done;
  logic               m_done_err;

  task automatic model_edge(input logic rst_v, input logic [NUM_REQ-1:0] r);
    logic [RV:0] calc;
    logic        found;
    m_done     = '0;
    m_done_err = 1'b0;
    if (rst_v) begin
      m_age    = 0;
      m_last   = NUM_REQ - 1;
      m_sticky = 1'b0;
      m_result = '0;
    end else if (m_age == 0) begin
      if (r != '0) begin
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
          if (!found && r[(m_last + i) % NUM_REQ]) begin
            found   = 1'b1;
            m_owner = (m_last + i) % NUM_REQ;
          end
        end
        m_a        = req_a[m_owner*AV +: AV];
        m_b        = req_b[m_owner*BV +: BV];
        m_snap_err = m_sticky;
        m_age      = 1;
      end
    end else begin
      m_age++;
      if (m_age == RUN + 3) begin
        calc              = outer(m_a, m_b);
        m_result          = calc[RV-1:0];
        m_done_err        = calc[RV] & ~m_snap_err;
        m_sticky          = m_sticky | calc[RV];
        m_done[m_owner]   = 1'b1;
        m_last            = m_owner;
        m_age             = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [RV-1:0] obs, input logic [RV-1:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge settles.
  task automatic applyStimulus(input logic rst_v, input logic [NUM_REQ-1:0] r);
    logic [NUM_REQ-1:0] eg;
    rst = rst_v;
    req = r;
    model_edge(rst_v, r);
    @(negedge clk);
    eg = '0;
    if (m_age >= 1) eg[m_owner] = 1'b1;
    checkOutput("ctrl", {grant, done, busy, tp_start}, {eg, m_done, m_age >= 1, m_age == 1});
    checkOutput("result", result, m_result);
    if (m_done != '0) checkOutput("done_error", done_error, m_done_err);
  endtask

  task automatic run_job(input logic [NUM_REQ-1:0] r, output int lat, output logic [NUM_REQ-1:0] seen);
    lat  = -1;
    seen = '0;
    for (int t = 1; t <= 60 && lat < 0; t++) begin
      applyStimulus(1'b0, r);
      if (done != '0) begin
        lat  = t;
        seen = done;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int t = 0; t < n; t++) applyStimulus(1'b0, '0);
  endtask

  initial begin
    int                 lat;
    logic [NUM_REQ-1:0] seen;
    logic [AV-1:0]      sa;
    logic [BV-1:0]      sb;
    logic [RV:0]        ex;
    logic [NUM_REQ-1:0] d_val [3];
    int                 d_cyc [3];
    int                 n_done;
    logic [NUM_REQ-1:0] rr;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = '0;
    req2   = '0;
    req_a  = '0;
    req_b  = '0;
    m_age  = 0;
    m_last = NUM_REQ - 1;
    m_owner = 0;
    m_a = '0; m_b = '0;
    m_sticky = 1'b0; m_snap_err = 1'b0;
    m_result = '0; m_done = '0; m_done_err = 1'b0;

    applyStimulus(1'b1, '0);
    applyStimulus(1'b1, '0);
    checkOutput("reset_ops", {tp_a, tp_b}, '0);
    checkOutput("reset_done_error", done_error, 1'b0);
    idle_cycles(3);

    // Unit job: 1.0 x 2.0 in every cell.
    req_a[0 +: AV] = {AL{8'h10}};
    req_b[0 +: BV] = {BL{8'h20}};
    run_job(2'b01, lat, seen);
    checkOutput("unit_latency", lat, 28);
    checkOutput("unit_done", seen, 2'b01);
    checkOutput("unit_result", result, {(AL*BL){8'h20}});
    checkOutput("unit_error", done_error, 1'b0);

    // Overflow sets done_error once; the following job sees the sticky flag and reports 0.
    req_a[0 +: AV] = {AL{8'h7F}};
    req_b[0 +: BV] = {BL{8'h7F}};
    run_job(2'b01, lat, seen);
    checkOutput("ovf_error", done_error, 1'b1);
    req_a[0 +: AV] = {AL{8'h08}};
    req_b[0 +: BV] = {BL{8'h10}};
    run_job(2'b01, lat, seen);
    checkOutput("post_ovf_error", done_error, 1'b0);
    checkOutput("post_ovf_result", result, {(AL*BL){8'h08}});

    applyStimulus(1'b1, '0);
    checkOutput("reset2_ops", {tp_a, tp_b}, '0);

    // Contention: both requesters held, grants alternate starting with requester 0.
    n_done = 0;
    for (int i = 0; i < 3; i++) begin d_val[i] = '0; d_cyc[i] = 0; end
    for (int t = 1; t <= 120; t++) begin
      applyStimulus(1'b0, 2'b11);
      if (done != '0 && n_done < 3) begin
        d_val[n_done] = done;
        d_cyc[n_done] = t;
        n_done++;
      end
    end
    checkOutput("rr_count", n_done, 3);
    checkOutput("rr_first", d_val[0], 2'b01);
    checkOutput("rr_second", d_val[1], 2'b10);
    checkOutput("rr_third", d_val[2], 2'b01);
    checkOutput("rr_first_time", d_cyc[0], 28);
    checkOutput("rr_spacing1", d_cyc[1] - d_cyc[0], 28);
    checkOutput("rr_spacing2", d_cyc[2] - d_cyc[1], 28);
    idle_cycles(30);

    // Owner's operands change during WAIT; latched copies must be used.
    sa = rand_vec();
    sb = rand_vec();
    req_a[AV +: AV] = sa;
    req_b[BV +: BV] = sb;
    applyStimulus(1'b0, 2'b10);
    for (int t = 0; t < 8; t++) begin
      req_a[AV +: AV] = rand_vec();
      req_b[BV +: BV] = rand_vec();
      applyStimulus(1'b0, 2'b10);
    end
    checkOutput("stable_tp_a", tp_a, sa);
    checkOutput("stable_tp_b", tp_b, sb);
    run_job(2'b10, lat, seen);
    ex = outer(sa, sb);
    checkOutput("stable_latency", lat + 9, 28);
    checkOutput("stable_result", result, ex[RV-1:0]);

    // Reset during WAIT cycle 10 aborts silently; a fresh request then completes normally.
    req_a[0 +: AV] = rand_vec();
    req_b[0 +: BV] = rand_vec();
    applyStimulus(1'b0, 2'b01);
    for (int t = 0; t < 10; t++) applyStimulus(1'b0, 2'b01);
    applyStimulus(1'b1, 2'b01);
    checkOutput("abort_ops", {tp_a, tp_b}, '0);
    checkOutput("abort_done_error", done_error, 1'b0);
    run_job(2'b01, lat, seen);
    checkOutput("abort_relaunch_latency", lat, 28);
    checkOutput("abort_relaunch_done", seen, 2'b01);

    // Randomized requesters: level requests, occasional abandonment, operands churning.
    rr = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if ($urandom_range(3) == 0) req_a[k*AV +: AV] = rand_vec();
        if ($urandom_range(3) == 0) req_b[k*BV +: BV] = rand_vec();
        if (rr[k]) begin
          if (m_done[k]) begin
            if ($urandom_range(3) != 0) rr[k] = 1'b0;
          end else if ($urandom_range(79) == 0) begin
            rr[k] = 1'b0;
          end
        end else if ($urandom_range(4) == 0) begin
          rr[k] = 1'b1;
        end
      end
      applyStimulus(1'b0, rr);
    end
    idle_cycles(30);

    // Tiled instance: 2x2 tiling gives 9 run cycles, done 12 cycles after sampling.
    req_a[0 +: AV] = rand_vec();
    req_b[0 +: BV] = rand_vec();
    lat  = -1;
    seen = '0;
    for (int t = 1; t <= 40 && lat < 0; t++) begin
      req2 = 2'b01;
      applyStimulus(1'b0, '0);
      if (done2 != '0) begin
        lat  = t;
        seen = done2;
      end
    end
    req2 = '0;
    checkOutput("tiled_latency", lat, 12);
    checkOutput("tiled_done", seen, 2'b01);
    checkOutput("tiled_result", result2, {AL{req_a[0 +: AV] ^ req_b[0 +: BV]}});
    checkOutput("tiled_idle", {grant2, busy2, tp_start2, done_error2}, '0);
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tensor_product_scheduler.md
TENSOR_PRODUCT_SCHEDULER -- requirements
Module: tensor_product_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one tensor_product unit.
REQ-002 SHALL have parameters A_VECTOR_LEN=5, B_VECTOR_LEN=5, A_CELL_WIDTH=8, B_CELL_WIDTH=8, RESULT_CELL_WIDTH=8, TILING_H=1, TILING_V=1, all matching the attached datapath.
REQ-003 SHALL define localparam RUN_CYCLES = ceil(A_VECTOR_LEN/TILING_V) * ceil(B_VECTOR_LEN/TILING_H).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester job request, level, held until that requester's done.
REQ-007 req_a  input  NUM_REQ*A_VECTOR_LEN*A_CELL_WIDTH  packed per-requester vector a, requester k at slice k.
REQ-008 req_b  input  NUM_REQ*B_VECTOR_LEN*B_CELL_WIDTH  packed per-requester vector b.
REQ-009 grant  output  NUM_REQ  one-hot owner of the datapath, 0 when idle.
REQ-010 done  output  NUM_REQ  one-cycle pulse to the owner when its result is available.
REQ-011 done_error  output  1  overflow flag for the completed job, valid only with a done pulse.
REQ-012 result  output  A_VECTOR_LEN*B_VECTOR_LEN*RESULT_CELL_WIDTH  registered copy of the last completed product.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 tp_start  output  1  start pulse to datapath.
REQ-015 tp_a / tp_b  output  A_VECTOR_LEN*A_CELL_WIDTH / B_VECTOR_LEN*B_CELL_WIDTH  operands to datapath.
REQ-016 tp_result  input  A_VECTOR_LEN*B_VECTOR_LEN*RESULT_CELL_WIDTH  datapath result.
REQ-017 tp_error  input  1  datapath error (sticky until its reset).

Function
REQ-018 SHALL implement states IDLE, LAUNCH, WAIT, CAPTURE.
REQ-019 IDLE: if any req bit is set, SHALL pick the winner round-robin, starting at index (last_grant+1) mod NUM_REQ; SHALL register grant, tp_a and tp_b from the winner's slices; SHALL go to LAUNCH.
REQ-020 LAUNCH: SHALL drive tp_start=1 for exactly this cycle, snapshot tp_error into err_snap, clear the wait counter, and go to WAIT.
REQ-021 WAIT: SHALL count RUN_CYCLES cycles, then go to CAPTURE; tp_start=0.
REQ-022 CAPTURE: SHALL register result<=tp_result, done<=grant, done_error<=tp_error & ~err_snap, last_grant<=winner index; SHALL clear grant and go to IDLE.
REQ-023 tp_a and tp_b SHALL stay constant from the IDLE sample through CAPTURE, because the datapath slices operands combinationally every RUN cycle.
REQ-024 Latency: req sampled in IDLE at cycle n -> tp_start at n+1 -> done pulse and new result at cycle n+3+RUN_CYCLES (n+28 at defaults).
REQ-025 The cycle carrying done SHALL be IDLE and SHALL already arbitrate, so back-to-back jobs are spaced 3+RUN_CYCLES cycles apart.
REQ-026 tp_valid SHALL NOT be used: the datapath valid is sticky, so completion is counter-based only.
REQ-027 If req drops mid-job, the job SHALL still complete and done SHALL still pulse; the owner's req bit SHALL NOT be re-granted in the same cycle its done pulses unless it is still asserted.
REQ-028 If tp_error was already high at LAUNCH, done_error SHALL be 0 for that job.
REQ-029 If there is only one requester, it SHALL be granted repeatedly; if there are no requests, the block SHALL stay in IDLE with grant=0.
REQ-030 result SHALL hold its value between completions.

Reset
REQ-031 On rst: state=IDLE, grant=0, done=0, done_error=0, tp_start=0, busy=0, result=0, tp_a=0, tp_b=0, last_grant=NUM_REQ-1 (so requester 0 wins first), counter=0, err_snap=0.
REQ-032 rst mid-job SHALL abort the job without a done pulse; the integrator SHALL reset the datapath with the same rst.

Verification
REQ-033 Single job at defaults: req=01, a=all 0x10, b=all 0x20 (1.0, 2.0) -> tp_start at n+1, done=01 at n+28, every result cell 0x20, done_error=0.
REQ-034 Contention: req=11 held -> grants alternate 01,10,01 with done pulses 28 cycles apart; no starvation.
REQ-035 Overflow: a cell 0x7F x b cell 0x7F -> done_error=1; next job with small values -> done_error=0 (tp_error stays sticky).
REQ-036 Operand stability: change req_a of the owner during WAIT -> tp_a unchanged, result matches the operands sampled at grant.
REQ-037 Reset at WAIT cycle 10 -> no done pulse, all outputs at reset values; a new req completes with nominal latency.
REQ-038 TILING_H=2, TILING_V=2, 5x5 -> RUN_CYCLES=9, done at n+12.
